lc3b_muldiv_unit: RTL and testbench
===================================

# lc3b_muldiv_unit

Iterative signed 16-bit multiply/divide responder that sits behind the execute stage of the LC-3b pipeline. Execute presents operands and an `lc3b_aluop`; when the op is `alu_mult` or `alu_div` this block asserts `stall_X` until the result is ready. It then holds `solution` until the pipeline signals `flow` to consume it. It is the serving end of the execute stage's stall/flow handshake.

## Interface
- `WIDTH`, 16: operand and result width; iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `sr1`  in  16  dividend / multiplicand (two's complement), after forwarding
- `sr2`  in  16  divisor / multiplier (two's complement), after forwarding
- `aluop`  in  `lc3b_aluop`  current execute op; only `alu_mult` and `alu_div` start work
- `flow`  in  1  pipeline advances this cycle (EX result latched into EX/MEM)
- `solution`  out  16  result register; reset 0
- `stall_X`  out  1  execute must hold; combinational, reset-state value = (aluop is mult/div)

## Operation
- Definition: `is_md` = (`aluop` == `alu_mult`) || (`aluop` == `alu_div`).
- States: IDLE, BUSY, FIX, DONE.
- `stall_X` = `is_md` && (state != DONE).
- IDLE
  - If `is_md`: capture |sr1| and |sr2| as unsigned 16-bit values (|0x8000| = 0x8000).
  - Capture result sign = sr1[15]^sr2[15], the op, and a div-by-zero flag (sr2 == 0).
  - Clear the accumulator and remainder, set count = 0, go to BUSY.
- BUSY, one step per cycle for 16 cycles (count 0..15), then go to FIX.
  - mult: shift-add; product register keeps only the low 16 bits.
  - div: restoring, MSB first; one quotient bit per cycle.
- FIX, one cycle.
  - Result = magnitude, negated if sign = 1, truncated to 16 bits.
  - div by zero: result forced to 0x0000.
  - Write `solution` and go to DONE.
- DONE
  - `stall_X` = 0; `solution` stable.
  - If `flow` = 1, go to IDLE. Otherwise hold indefinitely.
- Abort: in BUSY or FIX, if `is_md` drops (pipeline flush), go to IDLE next cycle. `solution` keeps its previous value.
- Operand changes on `sr1`/`sr2` after capture are ignored.
- Arithmetic
  - mult returns the low 16 bits of the signed product.
  - div returns the quotient truncated toward zero; the remainder is discarded.
  - 0x8000 / 0xFFFF = 0x8000 (wraps).
- Back-to-back ops: DONE with `flow` = 1 goes to IDLE. If the next instruction is also mult/div, it starts in IDLE on the following cycle; `stall_X` is already high there because it is combinational.
- Non-md ops: state remains IDLE and `stall_X` = 0. `solution` is ignored by execute.

## Timing
- Op first visible in IDLE at cycle 0.
- `stall_X` is high in cycles 0..17 (IDLE 1 + BUSY 16 + FIX 1).
- Cycle 18: DONE, `stall_X` low, `solution` valid. Latency is 18 cycles to result.
- Latency is fixed for all operands, including div by zero.
- Minimum 19 cycles between starts of consecutive md ops when `flow` is asserted immediately in DONE.
- Asynchronous reset in any state: state = IDLE, `solution` = 0, all internal registers = 0, count = 0.
- Abort takes effect one cycle after `is_md` drops. During that cycle `stall_X` is already 0 because `is_md` = 0.
- No output is combinationally dependent on `sr1`/`sr2`.

## Structure
- Add to `lc3b_types`:
  - `lc3b_muldiv_state` enum (IDLE, BUSY, FIX, DONE).
  - Constant `MULDIV_ITER` = 16.
- Reuse the existing `alu_mult` / `alu_div` members of `lc3b_aluop`; no new aluop encodings.
- One natural combinational sub-module, `muldiv_step`: given op, accumulator/remainder, operands and count, it produces the next accumulator/remainder. The FSM, counter and sign fix stay in the top.

## Test plan
- mult sr1 = 0x0007, sr2 = 0xFFFD, `flow` = 1 in DONE -> `stall_X` high exactly 18 cycles, then `solution` = 0xFFEB; IDLE next cycle.
- div 0xFFF9 / 0x0002 -> `solution` = 0xFFFD; div 0x0064 / 0x0007 -> 0x000E.
- div 0x0005 / 0x0000 -> `solution` = 0x0000 after 18 stall cycles; div 0x8000 / 0xFFFF -> 0x8000; mult 0x0100 * 0x0100 -> 0x0000.
- DONE with `flow` = 0 for 3 cycles -> `stall_X` = 0, `solution` constant.
  - Then `flow` = 1 with a second mult 0x0003 * 0x0004 presented -> restart, 18 stall cycles, `solution` = 0x000C.
- Assert `reset` at BUSY count 7 -> `solution` = 0, IDLE immediately, `stall_X` = `is_md`.
- Separately: change `aluop` to add at count 5 -> IDLE next cycle, prior `solution` retained.
- Non-md ops (add, and) for 10 cycles -> `stall_X` = 0 throughout; state remains IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b execute-stage types: ALU op encoding plus the multiply/divide FSM states.
package lc3b_types;

  typedef enum logic [3:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra, alu_mult, alu_div
  } lc3b_aluop;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} lc3b_muldiv_state;

  localparam int MULDIV_ITER = 16;

endpackage

// File: rtl/lc3b_muldiv_unit_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on operand magnitudes.
module muldiv_step
  import lc3b_types::*;
#(
  parameter int WIDTH = MULDIV_ITER,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [CW-1:0]    count_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam logic [CW-1:0] MSB = CW'(WIDTH - 1);

  logic [CW-1:0]    msb_idx;
  logic [WIDTH-1:0] shifted;

  // Divide walks the dividend MSB first, so count 0 pulls in bit WIDTH-1.
  assign msb_idx = MSB - count_i;
  assign shifted = {rem_i[WIDTH-2:0], a_i[msb_idx]};

  always_comb begin
    acc_o = acc_i;
    rem_o = rem_i;
    if (op_div_i) begin
      if (shifted >= b_i) begin
        rem_o = shifted - b_i;
        acc_o = {acc_i[WIDTH-2:0], 1'b1};
      end else begin
        rem_o = shifted;
        acc_o = {acc_i[WIDTH-2:0], 1'b0};
      end
    end else if (b_i[count_i]) begin
      acc_o = acc_i + (a_i << count_i);
    end
  end

endmodule

// File: rtl/lc3b_muldiv_unit.sv
// Iterative signed multiply/divide behind LC-3b execute; stalls EX for 18 cycles, then holds the result until flow.
module lc3b_muldiv_unit
  import lc3b_types::*;
#(
  parameter int WIDTH = MULDIV_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sr1,
  input  logic [WIDTH-1:0] sr2,
  input  lc3b_aluop        aluop,
  input  logic             flow,
  output logic [WIDTH-1:0] solution,
  output logic             stall_X
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  lc3b_muldiv_state state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, rem_q, rem_d, sol_q, sol_d;
  logic             sign_q, sign_d, div_q, div_d, dz_q, dz_d;
  logic             is_md;
  logic [WIDTH-1:0] step_acc, step_rem, fixed;

  assign is_md    = (aluop == alu_mult) || (aluop == alu_div);
  assign stall_X  = is_md && (state_q != DONE);
  assign solution = sol_q;
  assign fixed    = sign_q ? -acc_q : acc_q;

  muldiv_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
    .op_div_i (div_q),
    .acc_i    (acc_q),
    .rem_i    (rem_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .count_i  (count_q),
    .acc_o    (step_acc),
    .rem_o    (step_rem)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    sol_d   = sol_q;
    sign_d  = sign_q;
    div_d   = div_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: if (is_md) begin
        // Two's-complement negate of 0x8000 yields 0x8000, which is the correct unsigned magnitude.
        a_d     = sr1[WIDTH-1] ? -sr1 : sr1;
        b_d     = sr2[WIDTH-1] ? -sr2 : sr2;
        sign_d  = sr1[WIDTH-1] ^ sr2[WIDTH-1];
        div_d   = (aluop == alu_div);
        dz_d    = (sr2 == '0);
        acc_d   = '0;
        rem_d   = '0;
        count_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (!is_md) begin
          state_d = IDLE;
        end else begin
          acc_d   = step_acc;
          rem_d   = step_rem;
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (is_md) begin
          sol_d   = dz_q ? '0 : fixed;
          state_d = DONE;
        end
      end
      DONE: if (flow) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      sol_q   <= '0;
      sign_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      sol_q   <= sol_d;
      sign_q  <= sign_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_lc3b_muldiv_unit.sv
// Bench for lc3b_muldiv_unit: directed corner cases plus random ops against an integer-arithmetic model.
module tb_lc3b_muldiv_unit;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sr1 = '0, sr2 = '0;
  lc3b_aluop   aluop = alu_add;
  logic        flow = 1'b0;
  logic [15:0] solution;
  logic        stall_X;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_sol = '0;

  lc3b_muldiv_unit #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .sr1      (sr1),
    .sr2      (sr2),
    .aluop    (aluop),
    .flow     (flow),
    .solution (solution),
    .stall_X  (stall_X)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_md(input lc3b_aluop op, input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == alu_mult)  r = sa * sb;
    else if (sb == 0)    r = 0;
    else                 r = sa / sb;
    return r[15:0];
  endfunction

  // Presents an op in IDLE, counts stall cycles, holds DONE for `hold` cycles, then asserts flow.
  task automatic run_op(input lc3b_aluop op, input logic [15:0] a, input logic [15:0] b, input int hold);
    int n;
    logic [15:0] exp;
    exp = ref_md(op, a, b);
    @(negedge clk);
    flow = 1'b0; aluop = op; sr1 = a; sr2 = b;
    n = 0;
    #1;
    while (stall_X && n < 40) begin
      n++;
      @(negedge clk);
      sr1 = 16'($urandom);
      sr2 = 16'($urandom);
      #1;
    end
    chk("latency", n, 18);
    chk("result", solution, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk("hold_stall", stall_X, 0);
      chk("hold_sol", solution, exp);
    end
    last_sol = exp;
    flow = 1'b1;
  endtask

  logic [15:0] edge_vals [6] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h7FFF, 16'h0002};

  function automatic logic [15:0] pick();
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    // reset state
    #1;
    chk("rst_sol", solution, 0);
    chk("rst_stall_add", stall_X, 0);
    aluop = alu_mult; #1;
    chk("rst_stall_md", stall_X, 1);
    aluop = alu_add;
    @(negedge clk); reset = 1'b0;

    run_op(alu_mult, 16'h0007, 16'hFFFD, 0);
    @(negedge clk); flow = 1'b0; aluop = alu_add; #1;
    chk("idle_after_flow", stall_X, 0);

    run_op(alu_div, 16'hFFF9, 16'h0002, 1);
    run_op(alu_div, 16'h0064, 16'h0007, 0);
    run_op(alu_div, 16'h0005, 16'h0000, 0);
    run_op(alu_div, 16'h8000, 16'hFFFF, 0);
    run_op(alu_mult, 16'h0100, 16'h0100, 0);
    run_op(alu_mult, 16'h1234, 16'h0005, 3);
    run_op(alu_mult, 16'h0003, 16'h0004, 0);

    // reset during BUSY count 7
    @(negedge clk);
    flow = 1'b0; aluop = alu_div; sr1 = 16'h7000; sr2 = 16'h0003;
    repeat (8) @(negedge clk);
    reset = 1'b1; #1;
    chk("midrst_sol", solution, 0);
    chk("midrst_stall", stall_X, 1);
    aluop = alu_add; #1;
    chk("midrst_stall_add", stall_X, 0);
    @(negedge clk); reset = 1'b0;
    last_sol = '0;
    run_op(alu_div, 16'h7000, 16'h0003, 0);

    // abort at BUSY count 5
    @(negedge clk);
    flow = 1'b0; aluop = alu_mult; sr1 = 16'h0055; sr2 = 16'h0011;
    repeat (6) @(negedge clk);
    aluop = alu_add; #1;
    chk("abort_stall", stall_X, 0);
    chk("abort_sol", solution, last_sol);
    @(negedge clk); #1;
    chk("abort_sol2", solution, last_sol);
    run_op(alu_mult, 16'hFF00, 16'h0002, 0);

    // non-md ops keep the unit idle
    @(negedge clk); flow = 1'b0;
    for (int i = 0; i < 10; i++) begin
      aluop = (i % 2 == 0) ? alu_add : alu_and;
      sr1 = 16'($urandom); sr2 = 16'($urandom);
      #1;
      chk("nonmd_stall", stall_X, 0);
      chk("nonmd_sol", solution, last_sol);
      @(negedge clk);
    end

    // random ops
    for (int i = 0; i < 30; i++) begin
      run_op(($urandom_range(0, 1) == 0) ? alu_mult : alu_div, pick(), pick(), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk); flow = 1'b0; aluop = alu_sll; #1;
        chk("gap_stall", stall_X, 0);
      end
    end

    @(negedge clk); flow = 1'b0; aluop = alu_add;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
